rep_mem_wr_sched: RTL and testbench
===================================

# rep_mem_wr_sched

Write-port scheduler for the replicated-read multi-port memory (8 read ports, 1 write port `w1`). Shares the single write port among `NREQ` requesters with round-robin arbitration and a valid/ready handshake. After reset, or on command, it sweeps every memory word to zero, so all read replicas start from a known state. Sits directly in front of the memory's `w1_addr`/`w1_din`/`en_w1` inputs.

## Interface
- `BLOCKSIZE`, 10, address MSB index; address width AW = BLOCKSIZE+1, depth 2^AW = 2048
- `DW`, 32, data width
- `NREQ`, 4, number of write requesters (2..8)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  requester i holds a write
- `req_addr`  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- `req_data`  in  NREQ*DW  packed data, requester i at [i*DW +: DW]
- `req_ready`  out  NREQ  one-hot or zero; requester i accepted on `req_valid[i] & req_ready[i]` at posedge
- `clr_start`  in  1  one-cycle pulse: re-run the zero sweep
- `init_busy`  out  1  sweep in progress; all `req_ready` low
- `w1_addr`  out  AW  memory write address, registered
- `w1_din`  out  DW  memory write data, registered
- `en_w1`  out  1  memory write enable, registered
- `grant_id`  out  log2(NREQ)  requester index behind current `en_w1`, registered

## Operation
- States: INIT, RUN. Async reset enters INIT.
- INIT: sweep counter `cnt` (AW bits) starts at 0; each cycle drive `en_w1`=1, `w1_addr`=`cnt`, `w1_din`=0, `cnt`++. When the write of address 2^AW−1 is issued, go to RUN and clear `cnt`. No wrap past the top address. `grant_id`=0 throughout.
- RUN: round-robin over `req_valid`, starting from `last`+1 mod NREQ. `last` resets to NREQ−1, so requester 0 wins first. Winner i gets `req_ready[i]`=1 combinationally; others 0. On acceptance, register `w1_addr`/`w1_din` from requester i, `en_w1`=1, `grant_id`=i, `last`=i. With no valid request, `en_w1`=0 and `w1_addr`/`w1_din` hold their last values.
- Requesters must hold `req_addr`/`req_data` stable while `req_valid` is high and not accepted; dropping `req_valid` before acceptance is allowed.
- `clr_start` in RUN: all `req_ready` are forced low in that same cycle. Next edge enters INIT with `cnt`=0. A write registered on the prior edge still completes. `clr_start` during INIT is ignored.
- Same address from two requesters: serviced in grant order; last write wins. No merging.

## Timing
- Reset values: `en_w1`=0, `w1_addr`=0, `w1_din`=0, `grant_id`=0, `init_busy`=1, `req_ready`=0, `last`=NREQ−1, `cnt`=0.
- First sweep write: `en_w1` rises on the first posedge after `rst` deasserts.
- Sweep lasts 2^AW cycles (2048). `init_busy` falls on the edge that enters RUN. `req_ready` can assert in that same cycle.
- Latency: accept at edge N → `en_w1`/`w1_*` valid after edge N → memory updates at edge N+1 → all 8 read ports return new data after edge N+1.
- Throughput: one accepted write per cycle, sustained.
- Fairness: with all NREQ requesters valid continuously, each is granted once per NREQ cycles.
- `rst` asserted mid-sweep or mid-traffic: all outputs immediately return to reset values, and the full sweep restarts.

## Structure
- Shared package `rep_mem_pkg` holds:
  - `BLOCKSIZE`, `AW`, `DEPTH`, `DW` constants;
  - state typedef {INIT, RUN}.
- Sub-module `rr_arbiter`: parameterized NREQ; inputs request vector and `last`; outputs one-hot grant and encoded index; purely combinational.
- The top level holds the FSM, sweep counter, `last` register and output registers.

## Test plan
- Reset release: 2048 consecutive `en_w1`=1 cycles with `w1_addr` 0..2047 and `w1_din`=0. `init_busy` low exactly 2048 cycles after reset release. All 8 reads return 0 at random addresses.
- Single requester 2 writes addr 5, data 0xA5: `req_ready[2]` high the same cycle. `en_w1`=1, `w1_addr`=5, `grant_id`=2 next cycle. Reads of 5 return 0xA5 one cycle later.
- All 4 valid continuously for 8 cycles: `grant_id` sequence 0,1,2,3,0,1,2,3. No idle write cycles.
- Requesters 1 and 3 both target addr 7, data 0x11 and 0x33: grant order is 1 then 3, and addr 7 reads 0x33.
- `clr_start` pulsed with all requesters valid: no `req_ready` that cycle. Full 2048-cycle sweep follows; previously written addresses read 0 afterwards.
- `rst` pulsed low at sweep address 1000: outputs reset asynchronously. After release the sweep restarts at address 0 and takes 2048 cycles.

Source files
------------

// File: rtl/rep_mem_pkg.sv
// Shared constants and types for the replicated-read memory write path.
package rep_mem_pkg;

    localparam int unsigned BLOCKSIZE = 10;
    localparam int unsigned AW        = BLOCKSIZE + 1;
    localparam int unsigned DEPTH     = 1 << AW;
    localparam int unsigned DW        = 32;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IW'((32'(last_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rep_mem_wr_sched.sv
// Write-port scheduler: zero sweep after reset or clr_start, then round-robin
// sharing of the single memory write port among NREQ requesters.
module rep_mem_wr_sched
    import rep_mem_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clr_start,
    output logic                 init_busy,
    output logic [AW-1:0]        w1_addr,
    output logic [DW-1:0]        w1_din,
    output logic                 en_w1,
    output logic [IW-1:0]        grant_id
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [AW-1:0] w1_addr_q, w1_addr_d;
    logic [DW-1:0] w1_din_q, w1_din_d;
    logic          en_w1_q, en_w1_d;
    logic [IW-1:0] grant_id_q, grant_id_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            run_open;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    // clr_start blocks acceptance in the very cycle it is seen.
    assign run_open  = (state_q == StRun) && !clr_start;
    assign req_ready = run_open ? gnt : '0;
    assign accept    = |req_ready;
    assign init_busy = (state_q == StInit);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        w1_addr_d  = w1_addr_q;
        w1_din_d   = w1_din_q;
        en_w1_d    = 1'b0;
        grant_id_d = grant_id_q;
        unique case (state_q)
            StInit: begin
                en_w1_d    = 1'b1;
                w1_addr_d  = cnt_q;
                w1_din_d   = '0;
                grant_id_d = '0;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (clr_start) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end else if (accept) begin
                    en_w1_d    = 1'b1;
                    w1_addr_d  = sel_addr;
                    w1_din_d   = sel_data;
                    grant_id_d = gnt_idx;
                    last_d     = gnt_idx;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            last_q     <= IW'(NREQ - 1);
            w1_addr_q  <= '0;
            w1_din_q   <= '0;
            en_w1_q    <= 1'b0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            w1_addr_q  <= w1_addr_d;
            w1_din_q   <= w1_din_d;
            en_w1_q    <= en_w1_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign w1_addr  = w1_addr_q;
    assign w1_din   = w1_din_q;
    assign en_w1    = en_w1_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_rep_mem_wr_sched.sv
// Randomized bench for rep_mem_wr_sched against a behavioural scheduler and memory model.
module tb_rep_mem_wr_sched;
    import rep_mem_pkg::*;

    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                clr_start;
    logic                init_busy;
    logic [AW-1:0]       w1_addr;
    logic [DW-1:0]       w1_din;
    logic                en_w1;
    logic [IW-1:0]       grant_id;

    logic [AW-1:0] ra [NREQ];
    logic [DW-1:0] rd [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_addr[g*AW +: AW] = ra[g];
        assign req_data[g*DW +: DW] = rd[g];
    end

    rep_mem_wr_sched #(
        .NREQ(NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .init_busy (init_busy),
        .w1_addr   (w1_addr),
        .w1_din    (w1_din),
        .en_w1     (en_w1),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Memory as seen by the read ports, fed from the DUT write port.
    logic [DW-1:0] dut_mem [DEPTH];
    always @(posedge clk) if (en_w1) dut_mem[w1_addr] <= w1_din;

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_init;
    int            m_cnt, m_last, m_gid, m_acc;
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_init = 1; m_cnt = 0; m_last = NREQ - 1; m_gid = 0;
        m_en = 0; m_addr = '0; m_din = '0; m_acc = -1;
    endfunction

    // Winner is the valid requester closest after the last one, cyclically.
    function automatic int model_winner();
        int best, bd, d;
        best = -1;
        bd   = NREQ + 1;
        if (m_init || clr_start) return -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                d = (i - m_last - 1 + 2 * NREQ) % NREQ;
                if (d < bd) begin
                    bd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic void model_step();
        int w;
        w = model_winner();
        m_acc = w;
        if (m_init) begin
            m_en = 1; m_addr = AW'(m_cnt); m_din = '0; m_gid = 0;
            ref_mem[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) begin
                m_init = 0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (clr_start) begin
            m_en = 0; m_init = 1; m_cnt = 0;
        end else if (w >= 0) begin
            m_en = 1; m_addr = ra[w]; m_din = rd[w]; m_gid = w; m_last = w;
            ref_mem[ra[w]] = rd[w];
        end else begin
            m_en = 0;
        end
    endfunction

    // Starts and ends at a falling edge with inputs already applied.
    task automatic run_cycle();
        #1;
        check_eq("req_ready", 64'(req_ready), 64'(model_ready()));
        @(posedge clk);
        model_step();
        #1;
        check_eq("en_w1", 64'(en_w1), 64'(m_en));
        check_eq("w1_addr", 64'(w1_addr), 64'(m_addr));
        check_eq("w1_din", 64'(w1_din), 64'(m_din));
        check_eq("grant_id", 64'(grant_id), 64'(m_gid));
        check_eq("init_busy", 64'(init_busy), 64'(m_init));
        @(negedge clk);
    endtask

    task automatic read_ports();
        int a;
        for (int p = 0; p < 8; p++) begin
            a = $urandom_range(DEPTH - 1);
            check_eq("rd_port", 64'(dut_mem[a]), 64'(ref_mem[a]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_en"}, 64'(en_w1), 64'(0));
        check_eq({tag, "_addr"}, 64'(w1_addr), 64'(0));
        check_eq({tag, "_din"}, 64'(w1_din), 64'(0));
        check_eq({tag, "_gid"}, 64'(grant_id), 64'(0));
        check_eq({tag, "_busy"}, 64'(init_busy), 64'(1));
        check_eq({tag, "_ready"}, 64'(req_ready), 64'(0));
    endtask

    task automatic new_stim();
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && m_acc != i) begin
                if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
            end else begin
                req_valid[i] = ($urandom_range(2) != 0);
                ra[i] = AW'($urandom_range(15));
                rd[i] = $urandom;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        clr_start = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Initial sweep.
        rst = 1'b1;
        for (int n = 0; n < DEPTH; n++) run_cycle();
        check_eq("busy_after_sweep", 64'(init_busy), 64'(0));
        run_cycle();
        read_ports();

        // Single requester 2.
        req_valid = 4'b0100; ra[2] = AW'(5); rd[2] = 32'hA5;
        #1 check_eq("single_ready", 64'(req_ready), 64'(4'b0100));
        run_cycle();
        check_eq("single_addr", 64'(w1_addr), 64'(5));
        check_eq("single_gid", 64'(grant_id), 64'(2));
        req_valid = '0;
        run_cycle();
        check_eq("single_read", 64'(dut_mem[5]), 64'(32'hA5));

        // All requesters valid: one write every cycle, rotating grants.
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = AW'(20 + i);
            rd[i] = 32'h100 + i;
        end
        req_valid = '1;
        for (int n = 0; n < 8; n++) begin
            run_cycle();
            check_eq("full_no_idle", 64'(en_w1), 64'(1));
        end

        // Same address from 1 and 3, after requester 0 wins once.
        req_valid = 4'b0001; ra[0] = AW'(9); rd[0] = 32'h99;
        run_cycle();
        req_valid = 4'b1010;
        ra[1] = AW'(7); rd[1] = 32'h11;
        ra[3] = AW'(7); rd[3] = 32'h33;
        run_cycle();
        check_eq("same_gid_first", 64'(grant_id), 64'(1));
        req_valid = 4'b1000;
        run_cycle();
        check_eq("same_gid_second", 64'(grant_id), 64'(3));
        req_valid = '0;
        run_cycle();
        check_eq("same_addr_read", 64'(dut_mem[7]), 64'(32'h33));

        // Random traffic with periodic read checks.
        for (int n = 0; n < 1500; n++) begin
            new_stim();
            run_cycle();
            if (n % 150 == 149) begin
                req_valid = '0;
                run_cycle();
                read_ports();
            end
        end

        // clr_start with everyone valid.
        req_valid = '1;
        clr_start = 1'b1;
        #1 check_eq("clr_ready", 64'(req_ready), 64'(0));
        run_cycle();
        clr_start = 1'b0;
        for (int n = 0; n < DEPTH; n++) run_cycle();
        check_eq("busy_after_clr", 64'(init_busy), 64'(0));
        req_valid = '0;
        run_cycle();
        check_eq("clr_read5", 64'(dut_mem[5]), 64'(0));
        check_eq("clr_read7", 64'(dut_mem[7]), 64'(0));
        read_ports();

        // Async reset in the middle of a sweep.
        clr_start = 1'b1;
        run_cycle();
        clr_start = 1'b0;
        for (int n = 0; n < 1001; n++) run_cycle();
        check_eq("mid_sweep_addr", 64'(w1_addr), 64'(1000));
        rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        run_cycle();
        check_eq("restart_addr", 64'(w1_addr), 64'(0));
        for (int n = 1; n < DEPTH; n++) run_cycle();
        check_eq("busy_after_restart", 64'(init_busy), 64'(0));
        run_cycle();
        read_ports();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
